// File: rtl/lcd_char_feeder.sv
// lcd_char_feeder
//   Buffers character codes from a source in a small FIFO and hands them, one
//   at a time, to an LCD transaction layer. After reset it waits INIT_HOLD
//   cycles, requests LCD power-up (do_init) and waits for lcd_reset_done.
//   Once configured, each buffered byte is presented on data_to_write with a
//   single-cycle do_write_data pulse. The block then waits for the full
//   send_data_done handshake (high, then low) before popping the next byte.
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset           asynchronous, active-low reset
//   in_valid        source offers in_data this cycle
//   in_data[7:0]    character code from the source
//   in_ready        FIFO can take a byte this cycle
//   lcd_reset_done  transaction layer finished LCD configuration
//   send_data_done  transaction layer finished the current byte
//   do_init         request LCD power-up sequence
//   do_write_data   one-cycle request to write data_to_write
//   data_to_write   character presented to the transaction layer
//   fifo_level      number of bytes currently buffered
//   chars_sent      completed character writes (wraps at 16 bits)
//   busy            not idle, or bytes still buffered
module lcd_char_feeder #(
  parameter int DEPTH     = 16,
  parameter int INIT_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     lcd_reset_done,
  input  logic                     send_data_done,
  output logic                     do_init,
  output logic                     do_write_data,
  output logic [7:0]               data_to_write,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              chars_sent,
  output logic                     busy
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);
  localparam logic [7:0]    HOLD_LAST = 8'(INIT_HOLD - 1);

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT,
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t        state;
  logic [7:0]    init_cnt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept_en;
  logic          push;
  logic          pop;

  // accept_en keeps in_ready low while reset is held and for the reset-release
  // cycle itself; it rises on the first clock edge after release.
  assign in_ready = accept_en && (fifo_level != FULL_LVL);
  assign push     = in_valid && in_ready;
  // The only consumer of the FIFO is the IDLE state taking the head byte.
  assign pop      = (state == IDLE) && (fifo_level != '0);
  assign busy     = (state != IDLE) || (fifo_level != '0);

  // Storage array carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accept_en  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      accept_en <= 1'b1;
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= INIT_WAIT;
      init_cnt      <= '0;
      do_init       <= 1'b0;
      do_write_data <= 1'b0;
      data_to_write <= 8'h00;
      chars_sent    <= '0;
    end else begin
      case (state)
        INIT_WAIT: begin
          if (init_cnt == HOLD_LAST) begin
            state   <= INIT;
            do_init <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        INIT: begin
          if (lcd_reset_done) begin
            state   <= IDLE;
            do_init <= 1'b0;
          end
        end
        IDLE: begin
          // Head byte is latched on the same edge as the pop so it is already
          // stable during the do_write_data cycle.
          if (pop) begin
            data_to_write <= mem[rd_ptr];
            do_write_data <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          do_write_data <= 1'b0;
          state         <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (send_data_done) begin
            chars_sent <= chars_sent + 1'b1;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          // A long send_data_done level must not be taken as a second completion.
          if (!send_data_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state         <= INIT_WAIT;
          do_init       <= 1'b0;
          do_write_data <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_feeder.sv
module tb_lcd_char_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        lcd_reset_done;
  logic        send_data_done;
  logic        do_init;
  logic        do_write_data;
  logic [7:0]  data_to_write;
  logic [4:0]  fifo_level;
  logic [15:0] chars_sent;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          pulse_cnt = 0;
  logic [15:0] exp_chars = 16'd0;
  logic [7:0]  hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

  lcd_char_feeder #(.DEPTH(16), .INIT_HOLD(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .lcd_reset_done (lcd_reset_done),
    .send_data_done (send_data_done),
    .do_init        (do_init),
    .do_write_data  (do_write_data),
    .data_to_write  (data_to_write),
    .fifo_level     (fifo_level),
    .chars_sent     (chars_sent),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Counts cycles in which a write request is high (one per 1-cycle pulse).
  always @(negedge clk) begin
    if (reset === 1'b1 && do_write_data === 1'b1) pulse_cnt++;
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    lcd_reset_done = 1'b0;
    send_data_done = 1'b0;
    exp_chars = 16'd0;
    repeat (3) tick;
  endtask

  // Waits for the next write pulse, checks it, and completes the handshake.
  task serve(input logic [7:0] exp_d, input logic [4:0] exp_lvl);
    int n;
    n = 0;
    while (do_write_data !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    total++;
    if (do_write_data !== 1'b1) begin
      bad++;
      $display("FAIL serve_timeout: do_write_data=%b want 1 (data %h)", do_write_data, exp_d);
      return;
    end
    total++;
    if (data_to_write !== exp_d) begin bad++; $display("FAIL serve_data: got %h want %h", data_to_write, exp_d); end
    total++;
    if (fifo_level !== exp_lvl) begin bad++; $display("FAIL serve_level: got %0d want %0d", fifo_level, exp_lvl); end
    tick;
    total++;
    if (do_write_data !== 1'b0) begin bad++; $display("FAIL serve_pulse_width: got %b want 0", do_write_data); end
    send_data_done = 1'b1;
    tick;
    send_data_done = 1'b0;
    exp_chars = exp_chars + 16'd1;
    total++;
    if (chars_sent !== exp_chars) begin bad++; $display("FAIL serve_chars: got %0d want %0d", chars_sent, exp_chars); end
    tick;
  endtask

  task test_reset;
    do_reset;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (do_init !== 1'b0) begin bad++; $display("FAIL rst_do_init: got %b want 0", do_init); end
    total++; if (do_write_data !== 1'b0) begin bad++; $display("FAIL rst_dwd: got %b want 0", do_write_data); end
    total++; if (data_to_write !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", data_to_write); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    total++; if (chars_sent !== 16'd0) begin bad++; $display("FAIL rst_chars: got %0d want 0", chars_sent); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    reset = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", in_ready); end
  endtask

  task test_init;
    for (int i = 2; i <= 4; i++) begin
      tick;
      total++;
      if (do_init !== (i == 4)) begin bad++; $display("FAIL init_edge%0d: got %b want %b", i, do_init, (i == 4)); end
    end
    repeat (5) tick;
    total++; if (do_init !== 1'b1) begin bad++; $display("FAIL init_hold_high: got %b want 1", do_init); end
    lcd_reset_done = 1'b1;
    tick;
    total++; if (do_init !== 1'b0) begin bad++; $display("FAIL init_fall: got %b want 0", do_init); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_idle: busy got %b want 0", busy); end
  endtask

  task test_single;
    int p0;
    p0 = pulse_cnt;
    in_valid = 1'b1;
    in_data = 8'h41;
    tick;
    in_valid = 1'b0;
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    total++; if (do_write_data !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", do_write_data); end
    tick;
    total++; if (do_write_data !== 1'b1) begin bad++; $display("FAIL single_pulse: got %b want 1", do_write_data); end
    total++; if (data_to_write !== 8'h41) begin bad++; $display("FAIL single_data: got %h want 41", data_to_write); end
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (do_write_data !== 1'b0 || data_to_write !== 8'h41) begin
        bad++; $display("FAIL single_hold%0d: dwd=%b data=%h want 0/41", i, do_write_data, data_to_write);
      end
    end
    send_data_done = 1'b1;
    tick;
    send_data_done = 1'b0;
    exp_chars = exp_chars + 16'd1;
    total++; if (chars_sent !== 16'd1) begin bad++; $display("FAIL single_chars: got %0d want 1", chars_sent); end
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy got %b want 0", busy); end
    total++; if (data_to_write !== 8'h41) begin bad++; $display("FAIL single_stable: got %h want 41", data_to_write); end
    total++; if (pulse_cnt !== p0 + 1) begin bad++; $display("FAIL single_count: got %0d want %0d", pulse_cnt - p0, 1); end
  endtask

  task test_hello;
    int p0;
    do_reset;
    reset = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data = hello[k];
      tick;
    end
    in_valid = 1'b0;
    total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL hello_level: got %0d want 5", fifo_level); end
    total++; if (do_init !== 1'b1) begin bad++; $display("FAIL hello_init: got %b want 1", do_init); end
    p0 = pulse_cnt;
    lcd_reset_done = 1'b1;
    tick;
    for (int k = 0; k < 5; k++) serve(hello[k], 5'(4 - k));
    repeat (10) tick;
    total++; if (pulse_cnt !== p0 + 5) begin bad++; $display("FAIL hello_pulses: got %0d want 5", pulse_cnt - p0); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL hello_empty: got %0d want 0", fifo_level); end
    total++; if (chars_sent !== 16'd5) begin bad++; $display("FAIL hello_chars: got %0d want 5", chars_sent); end
  endtask

  task test_full;
    int p0;
    p0 = pulse_cnt;
    in_valid = 1'b1;
    in_data = 8'hA0;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h10 + i);
      total++;
      if (in_ready !== (i < 16)) begin bad++; $display("FAIL full_ready%0d: got %b want %b", i, in_ready, (i < 16)); end
      tick;
    end
    in_valid = 1'b0;
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level: got %0d want 16", fifo_level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data = 8'hEE;
    send_data_done = 1'b1;
    tick;
    send_data_done = 1'b0;
    exp_chars = exp_chars + 16'd1;
    tick;
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_pre_pop: got %0d want 16", fifo_level); end
    total++; if (data_to_write !== 8'hA0) begin bad++; $display("FAIL full_first: got %h want A0", data_to_write); end
    tick;
    in_valid = 1'b0;
    total++; if (fifo_level !== 5'd15) begin bad++; $display("FAIL full_pushpop: got %0d want 15", fifo_level); end
    for (int i = 0; i < 16; i++) serve(8'(8'h10 + i), 5'(15 - i));
    repeat (10) tick;
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", fifo_level); end
    total++; if (pulse_cnt !== p0 + 17) begin bad++; $display("FAIL full_pulses: got %0d want 17", pulse_cnt - p0); end
  endtask

  task test_sdd_hold;
    int p0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick;
    in_valid = 1'b0;
    tick;
    total++; if (do_write_data !== 1'b1 || data_to_write !== 8'h5A) begin bad++; $display("FAIL hold_pulse: dwd=%b data=%h want 1/5A", do_write_data, data_to_write); end
    tick;
    p0 = pulse_cnt;
    send_data_done = 1'b1;
    lcd_reset_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 2);
      in_data = 8'h5B;
      tick;
    end
    in_valid = 1'b0;
    exp_chars = exp_chars + 16'd1;
    total++; if (chars_sent !== exp_chars) begin bad++; $display("FAIL hold_chars: got %0d want %0d", chars_sent, exp_chars); end
    total++; if (pulse_cnt !== p0) begin bad++; $display("FAIL hold_no_pulse: got %0d want 0", pulse_cnt - p0); end
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL hold_level: got %0d want 1", fifo_level); end
    total++; if (do_init !== 1'b0) begin bad++; $display("FAIL hold_no_init: got %b want 0", do_init); end
    send_data_done = 1'b0;
    serve(8'h5B, 5'd0);
    lcd_reset_done = 1'b1;
  endtask

  task test_reset_mid;
    int p0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'hC1 + i);
      tick;
    end
    in_valid = 1'b0;
    total++; if (fifo_level !== 5'd3) begin bad++; $display("FAIL mid_level: got %0d want 3", fifo_level); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_rst_level: got %0d want 0", fifo_level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    total++; if (do_write_data !== 1'b0) begin bad++; $display("FAIL mid_rst_dwd: got %b want 0", do_write_data); end
    total++; if (data_to_write !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h want 00", data_to_write); end
    total++; if (chars_sent !== 16'd0) begin bad++; $display("FAIL mid_rst_chars: got %0d want 0", chars_sent); end
    total++; if (busy !== 1'b1 || do_init !== 1'b0) begin bad++; $display("FAIL mid_rst_busy_init: busy=%b init=%b want 1/0", busy, do_init); end
    exp_chars = 16'd0;
    repeat (3) tick;
    reset = 1'b1;
    p0 = pulse_cnt;
    repeat (30) tick;
    total++; if (pulse_cnt !== p0) begin bad++; $display("FAIL mid_no_write: got %0d pulses want 0", pulse_cnt - p0); end
    total++; if (busy !== 1'b0 || fifo_level !== 5'd0) begin bad++; $display("FAIL mid_idle: busy=%b level=%0d want 0/0", busy, fifo_level); end
    in_valid = 1'b1;
    in_data = 8'hD7;
    tick;
    in_valid = 1'b0;
    serve(8'hD7, 5'd0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    lcd_reset_done = 1'b0;
    send_data_done = 1'b0;
    test_reset;
    test_init;
    test_single;
    test_hello;
    test_full;
    test_sdd_hold;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
